// File: rtl/seg_carry_latch_adder_if.sv
// Operand/result handshake bundle for seg_carry_latch_adder.
// The slave side is the adder; the master side feeds operands and drains results.
interface seg_carry_latch_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/seg_carry_latch_adder.sv
// Pipelined WIDTH-bit add/subtract: one SEG-bit ripple per stage, inter-segment
// carry latched in a flop, lower result bits skewed forward with each entry.
module seg_carry_latch_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg_carry_latch_adder_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG;

    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_param_check
        $error("seg_carry_latch_adder: WIDTH must be a positive multiple of SEG");
    end

    // Link k carries what stage k consumes; link NSEG is the output side.
    logic             v_l [NSEG+1];
    logic [WIDTH-1:0] a_l [NSEG];
    logic [WIDTH-1:0] b_l [NSEG];
    logic [WIDTH-1:0] r_l [NSEG+1];
    logic             c_l [NSEG+1];
    logic             ovf_last;
    logic             adv;

    assign adv          = !v_l[NSEG] || bus.out_ready;
    assign bus.in_ready = adv;

    assign v_l[0] = bus.in_valid;
    assign a_l[0] = bus.a;
    assign b_l[0] = bus.sub ? ~bus.b : bus.b;
    assign r_l[0] = '0;
    assign c_l[0] = bus.sub | bus.cin;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        logic             v_q, v_d;
        logic             c_q, c_d;
        logic             ovf_q, ovf_d;
        logic [WIDTH-1:0] a_q, a_d;
        logic [WIDTH-1:0] b_q, b_d;
        logic [WIDTH-1:0] r_q, r_d;
        logic [SEG:0]     seg_sum;
        logic             msb_cin;

        always_comb begin
            seg_sum = {1'b0, a_l[gi][gi*SEG +: SEG]}
                    + {1'b0, b_l[gi][gi*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_l[gi]};
            // Carry into the segment's top bit, recovered from its sum bit.
            msb_cin = a_l[gi][gi*SEG + SEG - 1] ^ b_l[gi][gi*SEG + SEG - 1]
                    ^ seg_sum[SEG-1];
            v_d   = v_q;
            c_d   = c_q;
            ovf_d = ovf_q;
            a_d   = a_q;
            b_d   = b_q;
            r_d   = r_q;
            if (adv) begin
                v_d   = v_l[gi];
                c_d   = seg_sum[SEG];
                ovf_d = msb_cin ^ seg_sum[SEG];
                a_d   = a_l[gi];
                b_d   = b_l[gi];
                r_d   = r_l[gi];
                r_d[gi*SEG +: SEG] = seg_sum[SEG-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                r_q   <= '0;
            end else begin
                v_q   <= v_d;
                c_q   <= c_d;
                ovf_q <= ovf_d;
                a_q   <= a_d;
                b_q   <= b_d;
                r_q   <= r_d;
            end
        end

        assign v_l[gi+1] = v_q;
        assign r_l[gi+1] = r_q;
        assign c_l[gi+1] = c_q;

        if (gi < NSEG - 1) begin : g_inner
            logic unused_ovf;
            assign a_l[gi+1]  = a_q;
            assign b_l[gi+1]  = b_q;
            assign unused_ovf = ovf_q;
        end else begin : g_last
            // Operands are fully consumed by the final segment.
            logic unused_ops;
            assign unused_ops = ^{a_q, b_q};
            assign ovf_last   = ovf_q;
        end
    end

    assign bus.out_valid = v_l[NSEG];
    assign bus.sum       = r_l[NSEG];
    assign bus.cout      = c_l[NSEG];
    assign bus.ovf       = ovf_last;
endmodule
